// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types for the sequence-detector serializer path
package seq_pkg;

   // Serializer FSM states; PARITY is only reachable when the parity cycle is built in
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   // Widest parallel word the serializer is meant to carry
   localparam int SER_MAX_WIDTH = 32;

   // Parallel word container sized for the widest configuration
   typedef logic [SER_MAX_WIDTH-1:0] ser_word_t;

   // One serial beat as seen by the detector: the bit and its qualifier
   typedef struct packed {
      logic bits;
      logic valid;
   } ser_bit_t;

endpackage

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial feeder, optional parity cycle via SEQ_SERIALIZER_PARITY_EN
module seq_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             outbits,
   output logic             out_valid,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   ser_state_t       r_state;
   ser_state_t       w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;
   logic [CW-1:0]    r_cnt;
   logic             r_outbits;
   logic             r_out_valid;
   logic             w_load_ready;
   logic             w_xfer;
   logic             w_last;
   logic             w_load_bit;
   logic             w_shift_bit;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic             r_parity;
`endif

   assign w_last     = (r_cnt == '0);
   assign w_xfer     = load_valid & w_load_ready;
   assign load_ready = w_load_ready;
   assign outbits    = r_outbits;
   assign out_valid  = r_out_valid;
   assign busy       = (r_state != IDLE);

   // Select which end of the word leaves first; the register rotates so every
   // stored bit stays in use, the wrapped bit is never presented again
   always_comb begin
      if (MSB_FIRST) begin
         w_shift_next = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
         w_shift_bit  = r_shift[WIDTH-2];
         w_load_bit   = load_data[WIDTH-1];
      end else begin
         w_shift_next = {r_shift[0], r_shift[WIDTH-1:1]};
         w_shift_bit  = r_shift[1];
         w_load_bit   = load_data[0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and load_ready; ready depends only on state and counter
   always_comb begin
      w_state_next = r_state;
      w_load_ready = 1'b0;
      case (r_state)
         IDLE: begin
            w_load_ready = 1'b1;
            if (load_valid) begin
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
               w_state_next = PARITY;
`else
               w_load_ready = 1'b1;
               w_state_next = load_valid ? SHIFT : IDLE;
`endif
            end
         end
`ifdef SEQ_SERIALIZER_PARITY_EN
         PARITY: begin
            w_load_ready = 1'b1;
            w_state_next = load_valid ? SHIFT : IDLE;
         end
`endif
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Datapath: load on transfer, shift while bits remain, otherwise park at idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift     <= '0;
         r_cnt       <= '0;
         r_outbits   <= IDLE_BIT;
         r_out_valid <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else if (w_xfer) begin
         r_shift     <= load_data;
         r_cnt       <= LAST_IDX;
         r_outbits   <= w_load_bit;
         r_out_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
         r_parity    <= ^load_data;
`endif
      end else if (r_state == SHIFT && !w_last) begin
         r_shift     <= w_shift_next;
         r_cnt       <= r_cnt - CW'(1);
         r_outbits   <= w_shift_bit;
         r_out_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      end else if (r_state == SHIFT) begin
         // Last data bit just went out; the parity bit takes the next slot
         r_outbits   <= r_parity;
         r_out_valid <= 1'b1;
`endif
      end else begin
         r_shift     <= '0;
         r_outbits   <= IDLE_BIT;
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - directed table-driven bench for seq_serializer
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
   localparam int WPB = 9;
`else
   localparam int WPB = 8;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       lv_m, lr_m, ob_m, ov_m, bz_m;
   logic [7:0] ld_m;
   logic       lv_l, lr_l, ob_l, ov_l, bz_l;
   logic [7:0] ld_l;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
      logic       exp_p;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk(clk), .reset(reset), .load_valid(lv_m), .load_ready(lr_m),
      .load_data(ld_m), .outbits(ob_m), .out_valid(ov_m), .busy(bz_m)
   );

   seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk(clk), .reset(reset), .load_valid(lv_l), .load_ready(lr_l),
      .load_data(ld_l), .outbits(ob_l), .out_valid(ov_l), .busy(bz_l)
   );

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] em, el, w0, w1, w;
      logic       ep, eb;
      int         j;

      // word, MSB-first stream (bit7 leaves first), LSB-first stream, parity
      vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
      vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
      vecs[2] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
      vecs[3] = '{8'hC1, 8'b11000001, 8'b10000011, 1'b1};
      vecs[4] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
      vecs[5] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
      vecs[6] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};

      reset = 1'b1;
      lv_m = 1'b0; lv_l = 1'b0;
      ld_m = 8'h00; ld_l = 8'h00;

      // Reset values before the first clock edge
      #2;
      check("rst_ob_m", ob_m, 1'b0);
      check("rst_ov_m", ov_m, 1'b0);
      check("rst_bz_m", bz_m, 1'b0);
      check("rst_lr_m", lr_m, 1'b1);
      check("rst_ob_l", ob_l, 1'b0);
      check("rst_ov_l", ov_l, 1'b0);
      check("rst_bz_l", bz_l, 1'b0);
      check("rst_lr_l", lr_l, 1'b1);
      #5;
      reset = 1'b0;
      tick();

      // Single words through both bit orders
      for (int v = 0; v < 7; v++) begin
         em = vecs[v].exp_m;
         el = vecs[v].exp_l;
         ep = vecs[v].exp_p;
         ld_m = vecs[v].word; ld_l = vecs[v].word;
         lv_m = 1'b1; lv_l = 1'b1;
         check($sformatf("v%0d_idle_lr_m", v), lr_m, 1'b1);
         check($sformatf("v%0d_idle_lr_l", v), lr_l, 1'b1);
         tick();
         lv_m = 1'b0; lv_l = 1'b0;
         ld_m = 8'h5A; ld_l = 8'hC3;
         for (int i = 0; i < WPB; i++) begin
            check($sformatf("v%0d_b%0d_ov_m", v, i), ov_m, 1'b1);
            check($sformatf("v%0d_b%0d_ob_m", v, i), ob_m, (i < 8) ? em[7-i] : ep);
            check($sformatf("v%0d_b%0d_lr_m", v, i), lr_m, i == WPB - 1);
            check($sformatf("v%0d_b%0d_bz_m", v, i), bz_m, 1'b1);
            check($sformatf("v%0d_b%0d_ov_l", v, i), ov_l, 1'b1);
            check($sformatf("v%0d_b%0d_ob_l", v, i), ob_l, (i < 8) ? el[7-i] : ep);
            check($sformatf("v%0d_b%0d_lr_l", v, i), lr_l, i == WPB - 1);
            tick();
         end
         check($sformatf("v%0d_end_ov_m", v), ov_m, 1'b0);
         check($sformatf("v%0d_end_ob_m", v), ob_m, 1'b0);
         check($sformatf("v%0d_end_bz_m", v), bz_m, 1'b0);
         check($sformatf("v%0d_end_lr_m", v), lr_m, 1'b1);
         check($sformatf("v%0d_end_ov_l", v), ov_l, 1'b0);
         check($sformatf("v%0d_end_ob_l", v), ob_l, 1'b0);
      end

      // Back-to-back words with load_valid held high
`ifdef SEQ_SERIALIZER_PARITY_EN
      w0 = 8'h07; w1 = 8'h03;
`else
      w0 = 8'hA5; w1 = 8'h3C;
`endif
      ld_m = w0; lv_m = 1'b1;
      tick();
      ld_m = w1;
      for (int i = 0; i < 2 * WPB; i++) begin
         j  = i % WPB;
         w  = (i < WPB) ? w0 : w1;
         eb = (j < 8) ? w[7-j] : ^w;
         check($sformatf("b2b_%0d_ov", i), ov_m, 1'b1);
         check($sformatf("b2b_%0d_ob", i), ob_m, eb);
         check($sformatf("b2b_%0d_lr", i), lr_m, j == WPB - 1);
         tick();
         if (i == WPB - 1) begin
            lv_m = 1'b0;
            ld_m = 8'hFF;
         end
      end
      check("b2b_end_ov", ov_m, 1'b0);
      check("b2b_end_ob", ob_m, 1'b0);
      check("b2b_end_lr", lr_m, 1'b1);
      tick();
      check("b2b_gap_ov", ov_m, 1'b0);

      // Reset during the 4th bit of 8'hFF
      ld_m = 8'hFF; ld_l = 8'hFF;
      lv_m = 1'b1; lv_l = 1'b1;
      tick();
      lv_m = 1'b0; lv_l = 1'b0;
      tick(); tick(); tick();
      check("mid_pre_ov_m", ov_m, 1'b1);
      check("mid_pre_ob_m", ob_m, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_ov_m", ov_m, 1'b0);
      check("mid_rst_ob_m", ob_m, 1'b0);
      check("mid_rst_bz_m", bz_m, 1'b0);
      check("mid_rst_lr_m", lr_m, 1'b1);
      check("mid_rst_ov_l", ov_l, 1'b0);
      check("mid_rst_bz_l", bz_l, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("mid_after_%0d_ov_m", i), ov_m, 1'b0);
         check($sformatf("mid_after_%0d_bz_m", i), bz_m, 1'b0);
         check($sformatf("mid_after_%0d_ov_l", i), ov_l, 1'b0);
      end
      check("mid_after_lr_m", lr_m, 1'b1);
      check("mid_after_lr_l", lr_l, 1'b1);

      // Recovery: a fresh word streams normally after the aborted one
      ld_m = 8'h80; lv_m = 1'b1;
      tick();
      lv_m = 1'b0;
      check("rec_b0_ov", ov_m, 1'b1);
      check("rec_b0_ob", ob_m, 1'b1);
      tick();
      check("rec_b1_ob", ob_m, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
